sram_axi_bridge_mo: RTL and testbench

Multi-outstanding bridge between the CPU core's two SRAM-like ports (inst, data) and a single AXI3 master port, instantiated in the CPU top level between the core and the AXI interconnect. It generalises the single-transaction bridge. Each port can have up to `RD_DEPTH` reads in flight, and reads are issued back-to-back at one per cycle. Responses are steered to the owning port by AXI ID. Writes are issued from the data port only, and each port sees its responses in strict request order.

---
 rtl/sram_axi_bridge_mo_if.sv | 96 +++++++++
 rtl/sram_axi_bridge_mo.sv | 150 +++++++++++++++
 tb/tb_sram_axi_bridge_mo.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_mo_if.sv
// Signal bundle between the core's inst/data SRAM-like ports and the AXI3 master port.
// The bridge uses the master modport; the core/interconnect side uses slave.
interface sram_axi_bridge_mo_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_rdata, inst_addr_ok, inst_data_ok,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_rdata, inst_addr_ok, inst_data_ok,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge_mo.sv
// Multi-outstanding bridge: inst/data SRAM-like ports onto one AXI3 master.
// Reads are steered back by AXI ID; writes come from the data port only.
module sram_axi_bridge_mo #(
    parameter int unsigned RD_DEPTH = 4,
    parameter logic [3:0]  INST_ID  = 4'd0,
    parameter logic [3:0]  DATA_ID  = 4'd1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    sram_axi_bridge_mo_if.master        bus
);
    localparam int unsigned CW = $clog2(RD_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(RD_DEPTH);

    logic          r_rdy;
    logic [CW-1:0] r_cnt_i, r_cnt_d;
    logic          r_wr_pend;
    logic          r_arvalid, r_awvalid, r_wvalid;
    logic [31:0]   r_araddr, r_awaddr, r_wdata;
    logic [3:0]    r_arid, r_wstrb;
    logic [2:0]    r_arsize, r_awsize;

    logic w_ar_free, w_data_rd_ok, w_inst_rd_ok, w_wr_ok;
    logic w_r_hs, w_r_inst, w_r_data, w_b_hs;
    logic [3:0] w_strb;
    logic w_unused;

    // r_rdy gates every handshake so nothing is accepted while in or leaving reset
    assign w_ar_free    = !r_arvalid || bus.arready;
    assign w_data_rd_ok = r_rdy && bus.data_req && !bus.data_wr && w_ar_free
                          && (r_cnt_d < DEPTH) && !r_wr_pend;
    assign w_inst_rd_ok = r_rdy && bus.inst_req && w_ar_free
                          && (r_cnt_i < DEPTH) && !w_data_rd_ok;
    assign w_wr_ok      = r_rdy && bus.data_req && bus.data_wr
                          && (r_cnt_d == '0) && !r_wr_pend;

    assign w_r_hs   = bus.rvalid && r_rdy;
    assign w_r_inst = w_r_hs && (bus.rid == INST_ID);
    assign w_r_data = w_r_hs && (bus.rid == DATA_ID);
    assign w_b_hs   = bus.bvalid && r_rdy;

    always_comb begin
        w_strb = 4'b1111;
        case (bus.data_size)
            2'd0:    w_strb = 4'b0001 << bus.data_addr[1:0];
            2'd1:    w_strb = 4'b0011 << bus.data_addr[1:0];
            default: w_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdy     <= 1'b0;
            r_cnt_i   <= '0;
            r_cnt_d   <= '0;
            r_wr_pend <= 1'b0;
        end else begin
            r_rdy     <= 1'b1;
            r_cnt_i   <= r_cnt_i + CW'(w_inst_rd_ok) - CW'(w_r_inst);
            r_cnt_d   <= r_cnt_d + CW'(w_data_rd_ok) - CW'(w_r_data);
            if (w_wr_ok)
                r_wr_pend <= 1'b1;
            else if (w_b_hs)
                r_wr_pend <= 1'b0;
        end
    end

    // AR slot refills in its own drain cycle, giving one read per clock
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_arsize  <= '0;
        end else if (w_data_rd_ok) begin
            r_arvalid <= 1'b1;
            r_araddr  <= bus.data_addr;
            r_arid    <= DATA_ID;
            r_arsize  <= {1'b0, bus.data_size};
        end else if (w_inst_rd_ok) begin
            r_arvalid <= 1'b1;
            r_araddr  <= bus.inst_addr;
            r_arid    <= INST_ID;
            r_arsize  <= {1'b0, bus.inst_size};
        end else if (bus.arready) begin
            r_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awsize  <= '0;
        end else if (w_wr_ok) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= bus.data_addr;
            r_wdata   <= bus.data_wdata;
            r_wstrb   <= w_strb;
            r_awsize  <= {1'b0, bus.data_size};
        end else begin
            if (bus.awready) r_awvalid <= 1'b0;
            if (bus.wready)  r_wvalid  <= 1'b0;
        end
    end

    assign bus.inst_addr_ok = w_inst_rd_ok;
    assign bus.inst_data_ok = w_r_inst;
    assign bus.inst_rdata   = bus.rdata;
    assign bus.data_addr_ok = w_data_rd_ok || w_wr_ok;
    assign bus.data_data_ok = w_r_data || w_b_hs;
    assign bus.data_rdata   = bus.rdata;

    assign bus.arid    = r_arid;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = '0;
    assign bus.arsize  = r_arsize;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = '0;
    assign bus.arcache = '0;
    assign bus.arprot  = '0;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = r_rdy;

    assign bus.awid    = DATA_ID;
    assign bus.awaddr  = r_awaddr;
    assign bus.awlen   = '0;
    assign bus.awsize  = r_awsize;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = '0;
    assign bus.awcache = '0;
    assign bus.awprot  = '0;
    assign bus.awvalid = r_awvalid;
    assign bus.wid     = DATA_ID;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = r_wvalid;
    assign bus.bready  = r_rdy;

    assign w_unused = ^{bus.inst_wr, bus.inst_wdata, bus.rresp, bus.rlast, bus.bid, bus.bresp};

    a_rid_known: assert property (@(posedge aclk) disable iff (!aresetn)
        !(bus.rvalid && bus.rready && bus.rid != INST_ID && bus.rid != DATA_ID))
        else $error("R response with unknown rid %0h dropped", bus.rid);
endmodule

// File: tb/tb_sram_axi_bridge_mo.sv
// Directed bench for sram_axi_bridge_mo: bench acts as core and AXI slave, cycle by cycle.
module tb_sram_axi_bridge_mo;
    logic aclk = 1'b0;
    logic aresetn;
    int   vec  = 0;
    int   errs = 0;

    always #5 aclk = ~aclk;

    sram_axi_bridge_mo_if bus();

    sram_axi_bridge_mo #(.RD_DEPTH(4), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'd2;
        bus.inst_addr = '0; bus.inst_wdata = '0;
        bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd2;
        bus.data_addr = '0; bus.data_wdata = '0;
        bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
        bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b1; bus.rvalid = 1'b0;
        bus.bid = 4'd1; bus.bresp = '0; bus.bvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        idle();
        bus.inst_req = 1'b1; bus.data_req = 1'b1;
        #2;
        vec++; if (bus.arvalid !== 1'b0) begin errs++; $display("FAIL rst_arvalid got %b want 0", bus.arvalid); end
        vec++; if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin errs++; $display("FAIL rst_awwvalid got %b%b want 00", bus.awvalid, bus.wvalid); end
        vec++; if (bus.rready !== 1'b0 || bus.bready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b%b want 00", bus.rready, bus.bready); end
        vec++; if (bus.inst_addr_ok !== 1'b0 || bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL rst_addr_ok got %b%b want 00", bus.inst_addr_ok, bus.data_addr_ok); end
        tick(); tick();
        aresetn = 1'b1;
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        #1;
        vec++; if (bus.rready !== 1'b0) begin errs++; $display("FAIL rst_rready_pre got %b want 0", bus.rready); end
        tick();
        vec++; if (bus.rready !== 1'b1 || bus.bready !== 1'b1) begin errs++; $display("FAIL rst_ready_post got %b%b want 11", bus.rready, bus.bready); end
    endtask

    task automatic test_single_inst();
        tick();
        bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000; bus.inst_size = 2'd2;
        #1;
        vec++; if (bus.inst_addr_ok !== 1'b1) begin errs++; $display("FAIL single_addr_ok got %b want 1", bus.inst_addr_ok); end
        vec++; if (bus.arvalid !== 1'b0) begin errs++; $display("FAIL single_arvalid_T got %b want 0", bus.arvalid); end
        tick();
        bus.inst_req = 1'b0;
        #1;
        vec++; if (bus.arvalid !== 1'b1 || bus.arid !== 4'd0) begin errs++; $display("FAIL single_ar got v=%b id=%h want v=1 id=0", bus.arvalid, bus.arid); end
        vec++; if (bus.araddr !== 32'hBFC0_0000 || bus.arsize !== 3'd2) begin errs++; $display("FAIL single_ar_payload got %h/%0d want bfc00000/2", bus.araddr, bus.arsize); end
        vec++; if (bus.arlen !== 8'd0 || bus.arburst !== 2'b01 || bus.arcache !== 4'd0) begin errs++; $display("FAIL single_ar_fixed got len=%h burst=%b cache=%h want 0/01/0", bus.arlen, bus.arburst, bus.arcache); end
        tick();
        bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hDEAD_BEEF;
        #1;
        vec++; if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL single_data got ok=%b d=%h want 1/deadbeef", bus.inst_data_ok, bus.inst_rdata); end
        vec++; if (bus.data_data_ok !== 1'b0 || bus.arvalid !== 1'b0) begin errs++; $display("FAIL single_quiet got dok=%b arv=%b want 0/0", bus.data_data_ok, bus.arvalid); end
        tick();
        bus.rvalid = 1'b0;
        #1;
        vec++; if (bus.inst_data_ok !== 1'b0) begin errs++; $display("FAIL single_data_end got %b want 0", bus.inst_data_ok); end
    endtask

    task automatic test_back_to_back();
        int acc[6] = '{0, 1, 2, 3, 12, 13};
        int rc[6]  = '{11, 12, 13, 14, 23, 24};
        int k = 0;
        int j = 0;
        logic exp_ok, exp_dok;
        logic prev_acc = 1'b0;
        logic [31:0] prev_addr = '0;
        for (int c = 0; c < 27; c++) begin
            tick();
            bus.data_req = (k < 6); bus.data_wr = 1'b0; bus.data_size = 2'd2;
            bus.data_addr = 32'h0000_1000 + 32'(4 * k);
            bus.rvalid = (j < 6) && (c == rc[j]); bus.rid = 4'd1;
            bus.rdata = 32'hA000_0000 + 32'(j);
            #1;
            exp_ok  = (k < 6) && (c == acc[k]);
            exp_dok = (j < 6) && (c == rc[j]);
            vec++; if (bus.data_addr_ok !== exp_ok) begin errs++; $display("FAIL b2b_addr_ok c=%0d got %b want %b", c, bus.data_addr_ok, exp_ok); end
            vec++; if (bus.arvalid !== prev_acc) begin errs++; $display("FAIL b2b_arvalid c=%0d got %b want %b", c, bus.arvalid, prev_acc); end
            if (prev_acc) begin
                vec++; if (bus.araddr !== prev_addr) begin errs++; $display("FAIL b2b_araddr c=%0d got %h want %h", c, bus.araddr, prev_addr); end
            end
            vec++; if (bus.data_data_ok !== exp_dok) begin errs++; $display("FAIL b2b_data_ok c=%0d got %b want %b", c, bus.data_data_ok, exp_dok); end
            if (exp_dok) begin
                vec++; if (bus.data_rdata !== 32'hA000_0000 + 32'(j)) begin errs++; $display("FAIL b2b_rdata c=%0d got %h want %h", c, bus.data_rdata, 32'hA000_0000 + 32'(j)); end
            end
            prev_acc  = exp_ok;
            prev_addr = 32'h0000_1000 + 32'(4 * k);
            if (exp_ok) k++;
            if (exp_dok) j++;
        end
        tick();
        bus.rvalid = 1'b0; bus.data_req = 1'b0;
        #1;
        vec++; if (dut.r_cnt_d !== '0) begin errs++; $display("FAIL b2b_cnt_end got %0d want 0", dut.r_cnt_d); end
    endtask

    task automatic test_simultaneous();
        tick();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_2000;
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h0000_3000;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b1 || bus.inst_addr_ok !== 1'b0) begin errs++; $display("FAIL sim_prio got d=%b i=%b want 1/0", bus.data_addr_ok, bus.inst_addr_ok); end
        tick();
        bus.data_req = 1'b0;
        #1;
        vec++; if (bus.arvalid !== 1'b1 || bus.arid !== 4'd1 || bus.araddr !== 32'h0000_3000) begin errs++; $display("FAIL sim_ar_data got v=%b id=%h a=%h want 1/1/3000", bus.arvalid, bus.arid, bus.araddr); end
        vec++; if (bus.inst_addr_ok !== 1'b1) begin errs++; $display("FAIL sim_inst_ok got %b want 1", bus.inst_addr_ok); end
        tick();
        bus.inst_req = 1'b0;
        #1;
        vec++; if (bus.arvalid !== 1'b1 || bus.arid !== 4'd0 || bus.araddr !== 32'h0000_2000) begin errs++; $display("FAIL sim_ar_inst got v=%b id=%h a=%h want 1/0/2000", bus.arvalid, bus.arid, bus.araddr); end
        tick();
        bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h0000_0033;
        #1;
        vec++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0 || bus.data_rdata !== 32'h33) begin errs++; $display("FAIL sim_r_data got d=%b i=%b rd=%h want 1/0/33", bus.data_data_ok, bus.inst_data_ok, bus.data_rdata); end
        tick();
        bus.rid = 4'd0; bus.rdata = 32'h0000_0022;
        #1;
        vec++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0 || bus.inst_rdata !== 32'h22) begin errs++; $display("FAIL sim_r_inst got i=%b d=%b rd=%h want 1/0/22", bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata); end
        tick();
        bus.rvalid = 1'b0;
    endtask

    task automatic test_write_then_read();
        logic [1:0]  sz[3]  = '{2'd1, 2'd2, 2'd0};
        logic [31:0] ad[3]  = '{32'h0000_4102, 32'h0000_4200, 32'h0000_4301};
        logic [3:0]  stb[3] = '{4'b1100, 4'b1111, 4'b0010};
        tick();
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = 2'd0;
        bus.data_addr = 32'h0000_4003; bus.data_wdata = 32'hAB00_0000; bus.awready = 1'b0;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b1) begin errs++; $display("FAIL sb_addr_ok got %b want 1", bus.data_addr_ok); end
        tick();
        bus.data_wr = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h0000_4000;
        #1;
        vec++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin errs++; $display("FAIL sb_valids got aw=%b w=%b want 1/1", bus.awvalid, bus.wvalid); end
        vec++; if (bus.awaddr !== 32'h0000_4003 || bus.wstrb !== 4'b1000 || bus.awsize !== 3'd0) begin errs++; $display("FAIL sb_payload got a=%h s=%b sz=%0d want 4003/1000/0", bus.awaddr, bus.wstrb, bus.awsize); end
        vec++; if (bus.wdata !== 32'hAB00_0000 || bus.wlast !== 1'b1 || bus.awid !== 4'd1) begin errs++; $display("FAIL sb_wdata got d=%h last=%b id=%h want ab000000/1/1", bus.wdata, bus.wlast, bus.awid); end
        vec++; if (bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL raw_hold1 got %b want 0", bus.data_addr_ok); end
        tick();
        bus.awready = 1'b1;
        #1;
        vec++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b0) begin errs++; $display("FAIL sb_split got aw=%b w=%b want 1/0", bus.awvalid, bus.wvalid); end
        vec++; if (bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL raw_hold2 got %b want 0", bus.data_addr_ok); end
        tick();
        #1;
        vec++; if (bus.awvalid !== 1'b0 || bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL raw_hold3 got aw=%b ok=%b want 0/0", bus.awvalid, bus.data_addr_ok); end
        tick();
        bus.bvalid = 1'b1;
        #1;
        vec++; if (bus.data_data_ok !== 1'b1 || bus.bready !== 1'b1 || bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL sb_b got dok=%b br=%b aok=%b want 1/1/0", bus.data_data_ok, bus.bready, bus.data_addr_ok); end
        tick();
        bus.bvalid = 1'b0;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin errs++; $display("FAIL raw_release got aok=%b dok=%b want 1/0", bus.data_addr_ok, bus.data_data_ok); end
        tick();
        bus.data_req = 1'b0;
        #1;
        vec++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h0000_4000 || bus.arid !== 4'd1) begin errs++; $display("FAIL raw_ar got v=%b a=%h id=%h want 1/4000/1", bus.arvalid, bus.araddr, bus.arid); end
        tick();
        bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h0000_0055;
        #1;
        vec++; if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h55) begin errs++; $display("FAIL raw_r got ok=%b d=%h want 1/55", bus.data_data_ok, bus.data_rdata); end
        tick();
        bus.rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = sz[i]; bus.data_addr = ad[i];
            #1;
            vec++; if (bus.data_addr_ok !== 1'b1) begin errs++; $display("FAIL strb_addr_ok i=%0d got %b want 1", i, bus.data_addr_ok); end
            tick();
            bus.data_req = 1'b0;
            #1;
            vec++; if (bus.awvalid !== 1'b1 || bus.wstrb !== stb[i]) begin errs++; $display("FAIL strb i=%0d got v=%b s=%b want 1/%b", i, bus.awvalid, bus.wstrb, stb[i]); end
            tick();
            bus.bvalid = 1'b1;
            #1;
            vec++; if (bus.data_data_ok !== 1'b1) begin errs++; $display("FAIL strb_b i=%0d got %b want 1", i, bus.data_data_ok); end
            tick();
            bus.bvalid = 1'b0;
        end
    endtask

    task automatic test_write_blocked();
        tick();
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h0000_6000;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b1) begin errs++; $display("FAIL wb_rd0 got %b want 1", bus.data_addr_ok); end
        tick();
        bus.data_addr = 32'h0000_6004;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b1) begin errs++; $display("FAIL wb_rd1 got %b want 1", bus.data_addr_ok); end
        tick();
        bus.data_wr = 1'b1; bus.data_addr = 32'h0000_5000; bus.data_wdata = 32'h0000_1234; bus.data_size = 2'd2;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_7000;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b0 || bus.inst_addr_ok !== 1'b1) begin errs++; $display("FAIL wb_block0 got d=%b i=%b want 0/1", bus.data_addr_ok, bus.inst_addr_ok); end
        tick();
        bus.inst_addr = 32'h0000_7004;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b0 || bus.inst_addr_ok !== 1'b1) begin errs++; $display("FAIL wb_block1 got d=%b i=%b want 0/1", bus.data_addr_ok, bus.inst_addr_ok); end
        vec++; if (bus.arid !== 4'd0 || bus.araddr !== 32'h0000_7000) begin errs++; $display("FAIL wb_inst_ar got id=%h a=%h want 0/7000", bus.arid, bus.araddr); end
        tick();
        bus.inst_req = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h0000_0061;
        #1;
        vec++; if (bus.data_data_ok !== 1'b1 || bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL wb_r0 got dok=%b aok=%b want 1/0", bus.data_data_ok, bus.data_addr_ok); end
        tick();
        bus.rdata = 32'h0000_0062;
        #1;
        vec++; if (bus.data_data_ok !== 1'b1 || bus.data_addr_ok !== 1'b0) begin errs++; $display("FAIL wb_r1 got dok=%b aok=%b want 1/0", bus.data_data_ok, bus.data_addr_ok); end
        tick();
        bus.rvalid = 1'b0;
        #1;
        vec++; if (bus.data_addr_ok !== 1'b1) begin errs++; $display("FAIL wb_accept got %b want 1", bus.data_addr_ok); end
        tick();
        bus.data_req = 1'b0;
        #1;
        vec++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1 || bus.awaddr !== 32'h0000_5000 || bus.wstrb !== 4'b1111) begin errs++; $display("FAIL wb_aw got aw=%b w=%b a=%h s=%b want 1/1/5000/1111", bus.awvalid, bus.wvalid, bus.awaddr, bus.wstrb); end
        tick();
        bus.bvalid = 1'b1;
        #1;
        vec++; if (bus.data_data_ok !== 1'b1) begin errs++; $display("FAIL wb_b got %b want 1", bus.data_data_ok); end
        tick();
        bus.bvalid = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h0000_0071;
        #1;
        vec++; if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h71) begin errs++; $display("FAIL wb_ir0 got ok=%b d=%h want 1/71", bus.inst_data_ok, bus.inst_rdata); end
        tick();
        bus.rdata = 32'h0000_0072;
        #1;
        vec++; if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h72) begin errs++; $display("FAIL wb_ir1 got ok=%b d=%h want 1/72", bus.inst_data_ok, bus.inst_rdata); end
        tick();
        bus.rvalid = 1'b0;
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h0000_8000 + 32'(4 * i);
            #1;
            vec++; if (bus.data_addr_ok !== 1'b1) begin errs++; $display("FAIL rif_rd i=%0d got %b want 1", i, bus.data_addr_ok); end
        end
        tick();
        bus.data_req = 1'b0; bus.arready = 1'b0;
        #1;
        vec++; if (bus.arvalid !== 1'b1 || dut.r_cnt_d !== 3'd3) begin errs++; $display("FAIL rif_pre got arv=%b cnt=%0d want 1/3", bus.arvalid, dut.r_cnt_d); end
        aresetn = 1'b0;
        #1;
        vec++; if (bus.arvalid !== 1'b0 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin errs++; $display("FAIL rif_valids got ar=%b aw=%b w=%b want 000", bus.arvalid, bus.awvalid, bus.wvalid); end
        vec++; if (bus.rready !== 1'b0 || bus.bready !== 1'b0) begin errs++; $display("FAIL rif_ready got r=%b b=%b want 00", bus.rready, bus.bready); end
        vec++; if (dut.r_cnt_d !== '0 || dut.r_cnt_i !== '0) begin errs++; $display("FAIL rif_cnt got d=%0d i=%0d want 0/0", dut.r_cnt_d, dut.r_cnt_i); end
        tick();
        aresetn = 1'b1; bus.arready = 1'b1;
        #1;
        vec++; if (bus.rready !== 1'b0) begin errs++; $display("FAIL rif_rready_pre got %b want 0", bus.rready); end
        test_single_inst();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_inst();
        test_back_to_back();
        test_simultaneous();
        test_write_then_read();
        test_write_blocked();
        test_reset_inflight();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
